// File: rtl/byte_mem_wide.sv
// rtl/byte_mem_wide.sv - byte-addressed big-endian word memory with clear engine
//
// Purpose: storage array for the node data store. Each access touches
// WORD_BYTES consecutive bytes starting at 'address' (MSB first), with
// per-byte write enables and a registered read. A clear engine zeroes the
// whole array after reset (optional) and on request.
//
// Ports:
//   clock, reset          rising-edge clock, synchronous active-high reset
//   req_valid/req_ready   request handshake (accept when both high)
//   req_wr                1 = write, 0 = read
//   address               byte address of the most significant byte
//   byte_en               per-byte write enable, bit WORD_BYTES-1 = MSB
//   data_in               write data, MSB goes to memory[address]
//   clr_start             one-cycle pulse starting a clear sweep
//   clr_busy              high while the sweep runs
//   rd_valid              one-cycle pulse when data_out is updated
//   data_out              read data, held until the next read completes
module byte_mem_wide #(
   parameter int MEM_DEPTH      = 2048,
   parameter int ADDR_WIDTH     = 11,
   parameter int WORD_BYTES     = 2,
   parameter bit CLEAR_ON_RESET = 1'b1
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic                    req_wr,
   input  logic [ADDR_WIDTH-1:0]   address,
   input  logic [WORD_BYTES-1:0]   byte_en,
   input  logic [8*WORD_BYTES-1:0] data_in,
   input  logic                    clr_start,
   output logic                    clr_busy,
   output logic                    rd_valid,
   output logic [8*WORD_BYTES-1:0] data_out
);

   typedef enum logic {IDLE, CLEAR} state_t;

   localparam logic [ADDR_WIDTH-1:0] PTR_STEP = ADDR_WIDTH'(WORD_BYTES);
   localparam logic [ADDR_WIDTH-1:0] PTR_LAST = ADDR_WIDTH'(MEM_DEPTH - WORD_BYTES);

   state_t                state;
   logic [ADDR_WIDTH-1:0] ptr;
   logic [7:0]            mem [MEM_DEPTH];
   logic                  accept;

   // A clear request in the same cycle as an access takes priority.
   assign req_ready = (state == IDLE) && !clr_start;
   assign accept    = req_valid && req_ready;

   // Control FSM, registered outputs and read path.
   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= CLEAR_ON_RESET ? CLEAR : IDLE;
         clr_busy <= CLEAR_ON_RESET;
         ptr      <= '0;
         rd_valid <= 1'b0;
         data_out <= '0;
      end else begin
         rd_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (clr_start) begin
                  state    <= CLEAR;
                  clr_busy <= 1'b1;
                  ptr      <= '0;
               end else if (accept && !req_wr) begin
                  rd_valid <= 1'b1;
                  for (int k = 0; k < WORD_BYTES; k++)
                     data_out[8*(WORD_BYTES-1-k) +: 8] <= mem[address + ADDR_WIDTH'(k)];
               end
            end
            CLEAR: begin
               // clr_start is ignored here; the sweep never restarts mid-way.
               if (ptr == PTR_LAST) begin
                  state    <= IDLE;
                  clr_busy <= 1'b0;
               end
               ptr <= ptr + PTR_STEP;
            end
            default: begin
               state    <= IDLE;
               clr_busy <= 1'b0;
            end
         endcase
      end
   end

   // Storage array: no reset of contents; the clear engine handles that.
   // Address arithmetic wraps naturally at ADDR_WIDTH bits.
   always_ff @(posedge clock) begin
      if (!reset) begin
         if (state == CLEAR) begin
            for (int k = 0; k < WORD_BYTES; k++)
               mem[ptr + ADDR_WIDTH'(k)] <= 8'h00;
         end else if (accept && req_wr) begin
            for (int k = 0; k < WORD_BYTES; k++)
               if (byte_en[WORD_BYTES-1-k])
                  mem[address + ADDR_WIDTH'(k)] <= data_in[8*(WORD_BYTES-1-k) +: 8];
         end
      end
   end

endmodule

// File: tb/tb_byte_mem_wide.sv
// tb/tb_byte_mem_wide.sv - self-checking bench for byte_mem_wide
module tb_byte_mem_wide;

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   // instance A: WORD_BYTES=2
   logic        a_valid = 0, a_wr = 0, a_clr = 0;
   logic [10:0] a_addr = '0;
   logic [1:0]  a_be = '0;
   logic [15:0] a_din = '0;
   logic        a_ready, a_busy, a_rv;
   logic [15:0] a_dout;

   // instance B: WORD_BYTES=4
   logic        b_valid = 0, b_wr = 0, b_clr = 0;
   logic [10:0] b_addr = '0;
   logic [3:0]  b_be = '0;
   logic [31:0] b_din = '0;
   logic        b_ready, b_busy, b_rv;
   logic [31:0] b_dout;

   byte_mem_wide #(.MEM_DEPTH(2048), .ADDR_WIDTH(11), .WORD_BYTES(2), .CLEAR_ON_RESET(1'b1)) dut_a (
      .clock(clock), .reset(reset), .req_valid(a_valid), .req_ready(a_ready), .req_wr(a_wr),
      .address(a_addr), .byte_en(a_be), .data_in(a_din), .clr_start(a_clr), .clr_busy(a_busy),
      .rd_valid(a_rv), .data_out(a_dout));

   byte_mem_wide #(.MEM_DEPTH(2048), .ADDR_WIDTH(11), .WORD_BYTES(4), .CLEAR_ON_RESET(1'b1)) dut_b (
      .clock(clock), .reset(reset), .req_valid(b_valid), .req_ready(b_ready), .req_wr(b_wr),
      .address(b_addr), .byte_en(b_be), .data_in(b_din), .clr_start(b_clr), .clr_busy(b_busy),
      .rd_valid(b_rv), .data_out(b_dout));

   int total = 0;
   int bad   = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Behavioural model of instance A: memory as a byte array, the clear
   // sweep as a count of remaining cycles, and the last completed read.
   logic [7:0]  m_mem [2048];
   int          m_left = 0;
   int          m_base;
   logic        m_rv = 0;
   logic [15:0] m_do = '0;
   bit          m_live = 0;

   initial foreach (m_mem[i]) m_mem[i] = 8'h00;

   always @(posedge clock) begin
      if (reset) begin
         m_live = 1;
         m_left = 1024;
         m_rv   = 0;
         m_do   = '0;
      end else begin
         m_rv = 0;
         if (m_left > 0) begin
            m_base = (1024 - m_left) * 2;
            m_mem[m_base]     = 8'h00;
            m_mem[m_base + 1] = 8'h00;
            m_left--;
         end else if (a_clr) begin
            m_left = 1024;
         end else if (a_valid) begin
            if (a_wr) begin
               for (int k = 0; k < 2; k++)
                  if (a_be[1-k]) m_mem[(int'(a_addr) + k) % 2048] = a_din[8*(1-k) +: 8];
            end else begin
               m_do = {m_mem[int'(a_addr)], m_mem[(int'(a_addr) + 1) % 2048]};
               m_rv = 1;
            end
         end
      end
   end

   // Compare every cycle, away from the active edge.
   always @(negedge clock) begin
      if (m_live && !reset) begin
         chk("a_clr_busy", 64'(a_busy), 64'(m_left > 0));
         chk("a_req_ready", 64'(a_ready), 64'((m_left == 0) && !a_clr));
         chk("a_rd_valid", 64'(a_rv), 64'(m_rv));
         chk("a_data_out", 64'(a_dout), 64'(m_do));
      end
   end

   task automatic a_wrt(input logic [10:0] a, input logic [1:0] be, input logic [15:0] d, input string nm);
      a_valid = 1; a_wr = 1; a_addr = a; a_be = be; a_din = d;
      #1 chk({nm, "_ready"}, 64'(a_ready), 64'd1);
      @(posedge clock); #2;
      a_valid = 0; a_wr = 0;
      chk({nm, "_no_rv"}, 64'(a_rv), 64'd0);
   endtask

   task automatic a_rd(input logic [10:0] a, input logic [15:0] exp, input string nm);
      a_valid = 1; a_wr = 0; a_addr = a;
      #1 chk({nm, "_ready"}, 64'(a_ready), 64'd1);
      @(posedge clock); #2;
      a_valid = 0;
      chk({nm, "_rv"}, 64'(a_rv), 64'd1);
      chk(nm, 64'(a_dout), 64'(exp));
   endtask

   // Run until both sweeps end; optionally pulse a_clr at iteration pulse_at.
   task automatic sweep(input int pulse_at, output int na, output int nb);
      na = 0; nb = 0;
      for (int n = 0; n < 3000 && (a_busy || b_busy); n++) begin
         if (a_busy) na++;
         if (b_busy) nb++;
         a_clr = (n == pulse_at);
         @(posedge clock); #2;
      end
      a_clr = 0;
      chk("sweep_ends", 64'({a_busy, b_busy}), 64'd0);
   endtask

   initial begin
      int na, nb;
      repeat (2) @(posedge clock);
      #2 reset = 0;
      chk("reset_data_out", 64'(a_dout), 64'd0);
      chk("reset_rd_valid", 64'(a_rv), 64'd0);
      chk("reset_busy_a", 64'(a_busy), 64'd1);

      // 1: sweeps after reset, then memory reads zero
      sweep(-1, na, nb);
      chk("t1_busy_cycles_a", 64'(na), 64'd1024);
      chk("t1_busy_cycles_b", 64'(nb), 64'd512);
      a_rd(11'h648, 16'h0000, "t1_read");

      // 2: write then read next cycle; back-to-back reads
      a_wrt(11'h648, 2'b11, 16'h2000, "t2_wr");
      a_rd(11'h648, 16'h2000, "t2_read");
      a_rd(11'h647, 16'h0020, "t2_read_b2b");
      @(posedge clock); #2;
      chk("t2_rv_drops", 64'(a_rv), 64'd0);
      chk("t2_data_held", 64'(a_dout), 64'h0020);

      // 3: partial byte enables
      a_wrt(11'h010, 2'b11, 16'h1234, "t3_wr_full");
      a_wrt(11'h010, 2'b01, 16'hABCD, "t3_wr_lsb");
      a_rd(11'h010, 16'h12CD, "t3_read_lsb");
      a_wrt(11'h010, 2'b10, 16'h5A99, "t3_wr_msb");
      a_rd(11'h010, 16'h5ACD, "t3_read_msb");

      // 4: address wrap
      a_wrt(11'h7FF, 2'b11, 16'hBEEF, "t4_wr");
      a_rd(11'h7FF, 16'hBEEF, "t4_read_wrap");
      a_rd(11'h000, 16'hEF00, "t4_read_0");
      a_rd(11'h7FE, 16'h00BE, "t4_read_7fe");

      // 5: four-byte words, unaligned read
      b_valid = 1; b_wr = 1; b_addr = 11'h008; b_be = 4'hF; b_din = 32'hDEADBEEF;
      #1 chk("t5_b_ready", 64'(b_ready), 64'd1);
      @(posedge clock); #2;
      b_wr = 0; b_addr = 11'h009;
      @(posedge clock); #2;
      b_valid = 0;
      chk("t5_b_rv", 64'(b_rv), 64'd1);
      chk("t5_b_read", 64'(b_dout), 64'hADBEEF00);

      // 6: clear beats a simultaneous write; reset mid-sweep restarts it
      a_clr = 1; a_valid = 1; a_wr = 1; a_addr = 11'h020; a_be = 2'b11; a_din = 16'h5555;
      #1 chk("t6_ready_low", 64'(a_ready), 64'd0);
      @(posedge clock); #2;
      a_clr = 0; a_valid = 0; a_wr = 0;
      chk("t6_busy", 64'(a_busy), 64'd1);
      repeat (99) begin @(posedge clock); #2; end
      chk("t6_busy_at_100", 64'(a_busy), 64'd1);
      reset = 1;
      @(posedge clock); #2;
      reset = 0;
      chk("t6_reset_data_out", 64'(a_dout), 64'd0);
      sweep(-1, na, nb);
      chk("t6_busy_cycles_a", 64'(na), 64'd1024);
      chk("t6_busy_cycles_b", 64'(nb), 64'd512);
      a_rd(11'h020, 16'h0000, "t6_write_dropped");
      a_rd(11'h7FF, 16'h0000, "t6_cleared_wrap");

      // clr_start during a sweep is ignored
      a_clr = 1;
      @(posedge clock); #2;
      a_clr = 0;
      sweep(500, na, nb);
      chk("t7_no_restart", 64'(na), 64'd1024);
      chk("t7_data_held", 64'(a_dout), 64'd0);

      repeat (2) @(posedge clock);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
